rgbi_palette_expander: RTL and testbench



---
 rtl/rgbi_palette_expander.sv | 188 ++++++++++++++++++
 tb/tb_rgbi_palette_expander.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgbi_palette_expander.sv
// rgbi_palette_expander
// Expands 1-bit r/g/b plus intensity into OUT_W-bit channels through a
// writable multi-bank palette, generates the pixel clock enable and keeps
// blanks/syncs aligned with the colour outputs. The displayed bank only
// changes on a rising vblank sample, so a frame is never drawn with two banks.
// Optional build macro RGBI_TEST_PATTERN_EN adds an eight-bar colour test
// pattern selected by test_en; without it test_en has no effect.
module rgbi_palette_expander #(
    parameter int OUT_W   = 3,
    parameter int CE_DIV  = 8,
    parameter int NUM_PAL = 4
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       in_r,
    input  logic                       in_g,
    input  logic                       in_b,
    input  logic                       in_hi,
    input  logic                       in_hb,
    input  logic                       in_vb,
    input  logic                       in_hs,
    input  logic                       in_vs,
    input  logic [$clog2(NUM_PAL)-1:0] mode_sel,
    input  logic                       pal_wr,
    input  logic [$clog2(NUM_PAL)+3:0] pal_addr,
    input  logic [3*OUT_W-1:0]         pal_data,
    input  logic                       test_en,
    output logic                       ce_pix,
    output logic [OUT_W-1:0]           out_r,
    output logic [OUT_W-1:0]           out_g,
    output logic [OUT_W-1:0]           out_b,
    output logic                       out_hb,
    output logic                       out_vb,
    output logic                       out_hs,
    output logic                       out_vs,
    output logic [$clog2(NUM_PAL)-1:0] mode_active
);

    localparam int DIV_W   = $clog2(CE_DIV);
    localparam int ENT_W   = 3 * OUT_W;
    localparam int NUM_ENT = NUM_PAL * 16;

    // Default value of one channel: bank 1 is the dark ramp, all others bright.
    function automatic logic [OUT_W-1:0] chan_default(input logic dark, input logic h, input logic c);
        logic [OUT_W-1:0] v;
        if (dark) begin
            v            = '0;
            v[OUT_W-1]   = h & c;
            v[OUT_W-2]   = c;
        end else begin
            v            = {OUT_W{c}};
            v[OUT_W-2]   = h & c;
        end
        return v;
    endfunction

    // Default {R,G,B} entry for flat palette slot ent = {bank, hi, r, g, b}.
    function automatic logic [ENT_W-1:0] entry_default(input int ent);
        logic [3:0] idx;
        logic       dark;
        idx  = 4'(ent % 16);
        dark = ((ent / 16) == 1);
        return {chan_default(dark, idx[3], idx[2]),
                chan_default(dark, idx[3], idx[1]),
                chan_default(dark, idx[3], idx[0])};
    endfunction

    logic [DIV_W-1:0] div;
    logic             vb_prev;
    logic [ENT_W-1:0] pal [NUM_ENT];
    logic [3:0]       idx_p0;
    logic [3:0]       idx_p1;
    logic             hb_p1, vb_p1, hs_p1, vs_p1;
    logic [ENT_W-1:0] rd_p1;

    // Pixel divider: ce_pix is the registered (div == 0) of the previous cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div    <= '0;
            ce_pix <= 1'b0;
        end else begin
            ce_pix <= (div == '0);
            div    <= (div == DIV_W'(CE_DIV - 1)) ? '0 : div + DIV_W'(1);
        end
    end

    // Bank latch: take the requested bank only on a rising vblank sample.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vb_prev     <= 1'b0;
            mode_active <= '0;
        end else begin
            vb_prev <= in_vb;
            if (in_vb && !vb_prev)
                mode_active <= mode_sel;
        end
    end

    // Palette storage: reload defaults on reset, otherwise accept writes any cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENT; i++)
                pal[i] <= entry_default(i);
        end else if (pal_wr) begin
            pal[pal_addr] <= pal_data;
        end
    end

`ifdef RGBI_TEST_PATTERN_EN
    logic [7:0] col;
    logic       hb_prev;
    logic       unused_col_msb;

    assign unused_col_msb = col[7];

    // Column counter: restart at each hblank rise, count pixels while active.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            col     <= '0;
            hb_prev <= 1'b0;
        end else begin
            hb_prev <= in_hb;
            if (in_hb && !hb_prev)
                col <= '0;
            else if (ce_pix && !in_hb)
                col <= col + 8'd1;
        end
    end

    // Palette index: eight 16-pixel bars over the bright half when test_en is set.
    always_comb begin
        idx_p0 = {in_hi, in_r, in_g, in_b};
        if (test_en)
            idx_p0 = {1'b1, col[6:4]};
    end
`else
    logic unused_test_en;

    assign unused_test_en = test_en;

    // Palette index straight from the core colour bits.
    always_comb begin
        idx_p0 = {in_hi, in_r, in_g, in_b};
    end
`endif

    // ---- stage 1: capture index and blank/sync flags ----
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            idx_p1 <= '0;
            hb_p1  <= 1'b0;
            vb_p1  <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
        end else if (ce_pix) begin
            idx_p1 <= idx_p0;
            hb_p1  <= in_hb;
            vb_p1  <= in_vb;
            hs_p1  <= in_hs;
            vs_p1  <= in_vs;
        end
    end

    // ---- stage 2: palette lookup, blanking, output registers ----
    assign rd_p1 = pal[{mode_active, idx_p1}];

    // Output register: colour forced to black during either blank.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            out_r  <= '0;
            out_g  <= '0;
            out_b  <= '0;
            out_hb <= 1'b0;
            out_vb <= 1'b0;
            out_hs <= 1'b0;
            out_vs <= 1'b0;
        end else if (ce_pix) begin
            out_r  <= (hb_p1 || vb_p1) ? '0 : rd_p1[3*OUT_W-1 -: OUT_W];
            out_g  <= (hb_p1 || vb_p1) ? '0 : rd_p1[2*OUT_W-1 -: OUT_W];
            out_b  <= (hb_p1 || vb_p1) ? '0 : rd_p1[OUT_W-1:0];
            out_hb <= hb_p1;
            out_vb <= vb_p1;
            out_hs <= hs_p1;
            out_vs <= vs_p1;
        end
    end

endmodule

// File: tb/tb_rgbi_palette_expander.sv
// Bench for rgbi_palette_expander: reset state, divider timing (CE_DIV 8 and 3),
// default palette lookups, deferred bank switch, palette write with same-edge
// read, blanking, mid-frame reset and test_en handling. Expected pixels are
// pushed to a queue as they are driven and popped two ce_pix pulses later.
module tb_rgbi_palette_expander;

    logic       clk_sys;
    logic       reset;
    logic       in_r, in_g, in_b, in_hi, in_hb, in_vb, in_hs, in_vs;
    logic [1:0] mode_sel;
    logic       pal_wr;
    logic [5:0] pal_addr;
    logic [8:0] pal_data;
    logic       test_en;
    logic       ce_pix;
    logic [2:0] out_r, out_g, out_b;
    logic       out_hb, out_vb, out_hs, out_vs;
    logic [1:0] mode_active;

    logic       ce3;
    logic [2:0] unused3_r, unused3_g, unused3_b;
    logic       unused3_hb, unused3_vb, unused3_hs, unused3_vs;
    logic [1:0] unused3_mode;

    int n_chk = 0;
    int n_bad = 0;

    // model state
    logic [8:0]  mp [64];
    logic [1:0]  m_mode;
    logic        m_vb_prev;
    logic        m_hb_prev;
    logic [7:0]  col_m;
    logic [12:0] sb [$];
    logic        te;
    logic [5:0]  wr_addr;
    logic [8:0]  wr_data;

    rgbi_palette_expander #(.OUT_W(3), .CE_DIV(8), .NUM_PAL(4)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_hi(in_hi),
        .in_hb(in_hb), .in_vb(in_vb), .in_hs(in_hs), .in_vs(in_vs),
        .mode_sel(mode_sel), .pal_wr(pal_wr), .pal_addr(pal_addr),
        .pal_data(pal_data), .test_en(test_en), .ce_pix(ce_pix),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_hb(out_hb), .out_vb(out_vb), .out_hs(out_hs), .out_vs(out_vs),
        .mode_active(mode_active)
    );

    rgbi_palette_expander #(.OUT_W(3), .CE_DIV(3), .NUM_PAL(4)) dut3 (
        .clk_sys(clk_sys), .reset(reset),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_hi(in_hi),
        .in_hb(in_hb), .in_vb(in_vb), .in_hs(in_hs), .in_vs(in_vs),
        .mode_sel(mode_sel), .pal_wr(1'b0), .pal_addr(pal_addr),
        .pal_data(pal_data), .test_en(test_en), .ce_pix(ce3),
        .out_r(unused3_r), .out_g(unused3_g), .out_b(unused3_b),
        .out_hb(unused3_hb), .out_vb(unused3_vb), .out_hs(unused3_hs), .out_vs(unused3_vs),
        .mode_active(unused3_mode)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Default entry values written out as the table for a 3-bit channel.
    function automatic logic [2:0] dflt(input int bank, input logic h, input logic c);
        if (!c)
            return 3'b000;
        if (bank == 1)
            return h ? 3'b110 : 3'b010;
        return h ? 3'b111 : 3'b101;
    endfunction

    task automatic model_reset();
        logic [3:0] ix;
        for (int bk = 0; bk < 4; bk++) begin
            for (int i = 0; i < 16; i++) begin
                ix = 4'(i);
                mp[bk*16+i] = {dflt(bk, ix[3], ix[2]), dflt(bk, ix[3], ix[1]), dflt(bk, ix[3], ix[0])};
            end
        end
        m_mode    = 2'd0;
        m_vb_prev = 1'b0;
        m_hb_prev = 1'b0;
        col_m     = 8'd0;
        sb.delete();
    endtask

    // One pixel per ce_pix pulse: optionally write the palette on this pulse's
    // edge, check the output produced at that edge, then drive the next pixel.
    task automatic pix(input logic r, g, b, hi, hb, vb, hs, vs, input logic wr);
        int          guard;
        logic [3:0]  idx;
        logic [8:0]  e;
        logic [12:0] exp, got;
        guard = 0;
        @(negedge clk_sys);
        while (!ce_pix && guard < 64) begin
            @(negedge clk_sys);
            guard++;
        end
        if (!ce_pix)
            chk("ce_wait", 32'(ce_pix), 32'd1);
        if (wr) begin
            pal_wr   = 1'b1;
            pal_addr = wr_addr;
            pal_data = wr_data;
        end
        @(posedge clk_sys);
        #1;
        if (wr) begin
            pal_wr      = 1'b0;
            mp[wr_addr] = wr_data;
        end
        got = {out_hb, out_vb, out_hs, out_vs, out_r, out_g, out_b};
        if (sb.size() == 2) begin
            exp = sb.pop_front();
            chk("pix", 32'(got), 32'(exp));
        end
        chk("mode", 32'(mode_active), 32'(m_mode));
        in_r = r; in_g = g; in_b = b; in_hi = hi;
        in_hb = hb; in_vb = vb; in_hs = hs; in_vs = vs;
        test_en = te;
        if (vb && !m_vb_prev)
            m_mode = mode_sel;
        m_vb_prev = vb;
        idx = {hi, r, g, b};
`ifdef RGBI_TEST_PATTERN_EN
        if (hb && !m_hb_prev)
            col_m = 8'd0;
        if (te)
            idx = {1'b1, col_m[6:4]};
        if (!hb)
            col_m = col_m + 8'd1;
`endif
        m_hb_prev = hb;
        e   = mp[{m_mode, idx}];
        exp = (hb || vb) ? {hb, vb, hs, vs, 9'd0} : {hb, vb, hs, vs, e};
        sb.push_back(exp);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out"}, 32'({out_hb, out_vb, out_hs, out_vs, out_r, out_g, out_b}), 32'd0);
        chk({tag, "_mode"}, 32'(mode_active), 32'd0);
        chk({tag, "_ce"}, 32'(ce_pix), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        {in_r, in_g, in_b, in_hi, in_hb, in_vb, in_hs, in_vs} = '0;
        mode_sel = 2'd0; pal_wr = 1'b0; pal_addr = '0; pal_data = '0;
        test_en = 1'b0; te = 1'b0; wr_addr = '0; wr_data = '0;
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        check_reset_state("rst");
        reset = 1'b0;

        // divider: pulses after edges 1, 9, 17 (CE_DIV=8) and 1, 4, 7... (CE_DIV=3)
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_sys);
            #1;
            chk("ce8", 32'(ce_pix), 32'(k % 8 == 1));
            chk("ce3", 32'(ce3), 32'(k % 3 == 1));
        end

        // bank 0 defaults
        pix(1, 0, 1, 1, 0, 0, 0, 0, 0);
        pix(1, 0, 1, 0, 0, 0, 0, 0, 0);
        pix(0, 1, 0, 1, 0, 0, 0, 0, 0);
        pix(1, 1, 1, 0, 0, 0, 0, 0, 0);

        // mid-frame bank request has no effect until the vblank rise
        mode_sel = 2'd1;
        pix(1, 0, 0, 0, 0, 0, 0, 0, 0);
        pix(1, 1, 1, 1, 0, 0, 0, 0, 0);
        pix(1, 1, 1, 1, 1, 0, 0, 0, 0);
        pix(1, 1, 1, 1, 0, 1, 0, 1, 0);
        pix(1, 1, 1, 1, 0, 1, 0, 1, 0);
        pix(1, 0, 0, 0, 0, 0, 0, 0, 0);
        pix(1, 1, 1, 1, 0, 0, 0, 0, 0);

        // palette write to bank 2 entry F, read of that entry on the same edge
        mode_sel = 2'd2;
        pix(0, 0, 0, 0, 1, 0, 0, 0, 0);
        pix(0, 0, 0, 0, 0, 1, 0, 0, 0);
        pix(1, 1, 1, 1, 0, 0, 0, 0, 0);
        pix(0, 0, 0, 0, 1, 0, 0, 0, 0);
        wr_addr = {2'd2, 4'hF};
        wr_data = 9'h1C3;
        pix(1, 1, 1, 1, 0, 0, 0, 0, 1);
        pix(1, 1, 1, 1, 0, 0, 0, 0, 0);
        pix(1, 0, 1, 0, 0, 0, 0, 0, 0);

        // blanking with white input, syncs pass through
        pix(1, 1, 1, 1, 1, 0, 1, 0, 0);
        pix(1, 1, 1, 1, 0, 0, 1, 1, 0);
        pix(1, 1, 1, 1, 1, 0, 0, 1, 0);
        pix(0, 1, 1, 0, 0, 0, 0, 0, 0);
        pix(1, 1, 0, 1, 0, 0, 0, 0, 0);

        // reset mid-frame with live pixels in flight
        reset = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        check_reset_state("mid_rst");
        {in_r, in_g, in_b, in_hi, in_hb, in_vb, in_hs, in_vs} = '0;
        model_reset();
        reset = 1'b0;

`ifdef RGBI_TEST_PATTERN_EN
        // colour bars across 128 columns of bank 0
        pix(0, 0, 0, 0, 1, 0, 0, 0, 0);
        te = 1'b1;
        for (int i = 0; i < 128; i++)
            pix(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                1'($urandom_range(1)), 0, 0, 0, 0, 0);
        te = 1'b0;
        pix(0, 0, 0, 0, 1, 0, 0, 0, 0);
`else
        // test_en has no effect in this build
        te = 1'b1;
        pix(1, 0, 1, 1, 0, 0, 0, 0, 0);
        pix(0, 1, 0, 0, 0, 0, 0, 0, 0);
        te = 1'b0;
        pix(1, 1, 0, 1, 0, 0, 0, 0, 0);
`endif

        // after reset: bank 0, then bank 2 shows its default, not the written value
        pix(1, 1, 1, 1, 0, 0, 0, 0, 0);
        pix(0, 0, 0, 0, 1, 0, 0, 0, 0);
        pix(0, 0, 0, 0, 0, 1, 0, 0, 0);
        pix(1, 1, 1, 1, 0, 0, 0, 0, 0);
        pix(1, 0, 0, 0, 0, 0, 0, 0, 0);
        pix(0, 0, 0, 0, 1, 0, 0, 0, 0);
        pix(0, 0, 0, 0, 1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
